// File: rtl/stopwatch_pkg.sv
// Shared encodings and defaults for the stopwatch control front end.
// Optional button debounce is enabled with the BTN_DEBOUNCE_EN macro.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_e;

    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;
    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/stopwatch_control_btn_conditioner.sv
// Raw button -> 2-flop sync -> optional debounce (BTN_DEBOUNCE_EN) -> rising-edge pulse.
// A level held high yields exactly one pulse.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc_q;
    logic             acc_d;

    // Counts consecutive synced samples that disagree with the accepted level.
    always_comb begin
        cnt_d = '0;
        acc_d = acc_q;
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_MAX) begin
                acc_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign level = acc_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control: button conditioning, IDLE/RUNNING/PAUSED FSM and tick prescaler.
// Define BTN_DEBOUNCE_EN to add per-button debounce of DEBOUNCE_CYCLES samples.
import stopwatch_pkg::*;

module stopwatch_control #(
    parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
    output logic       tick,
    output logic       counter_clr_n,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic start_ev;
    logic stop_ev;
    logic clr_ev;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clr_n_q, clr_n_d;
    logic          running_q, running_d;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (start_btn),
        .pulse_o (start_ev)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (stop_btn),
        .pulse_o (stop_ev)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (clear_btn),
        .pulse_o (clr_ev)
    );

    // Stop outranks start, so stop+start in IDLE/PAUSED leaves the state alone.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clr_n_d = 1'b1;
        if (clr_ev) begin
            state_d = ST_IDLE;
            presc_d = '0;
            clr_n_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (!stop_ev && start_ev) state_d = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (presc_q == LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (stop_ev) state_d = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (!stop_ev && start_ev) state_d = ST_RUNNING;
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase
        end
        running_d = (state_d == ST_RUNNING);
    end

    // Counters stay cleared while the block is held in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            clr_n_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            clr_n_q   <= clr_n_d;
            running_q <= running_d;
        end
    end

    assign tick          = tick_q;
    assign counter_clr_n = clr_n_q;
    assign running       = running_q;
    assign state         = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed + random bench for stopwatch_control against a cycle-count reference model.
module tb_stopwatch_control;

    localparam int TD = 4;
    localparam int DB = 3;
`ifdef BTN_DEBOUNCE_EN
    localparam int PRESS = DB + 2;
`else
    localparam int PRESS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       stop_btn;
    logic       clear_btn;
    logic       tick;
    logic       counter_clr_n;
    logic       running;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // Reference model: button history per edge, accepted levels, run-cycle count.
    bit hq[3][$];
    bit lq[3][$];
    int m_state;
    int m_run;
    bit m_tick;
    bit m_clrn;

    stopwatch_control #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .stop_btn      (stop_btn),
        .clear_btn     (clear_btn),
        .tick          (tick),
        .counter_clr_n (counter_clr_n),
        .running       (running),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit hget(input int b, input int i);
        if (i < 0) return 1'b0;
        return hq[b][i];
    endfunction

    function automatic bit lget(input int b, input int i);
        if (i < 0) return 1'b0;
        return lq[b][i];
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit p, input bit c);
        bit ev[3];
        bit smp[3];
        int n;
        if (r) begin
            for (int b = 0; b < 3; b++) begin
                hq[b].delete();
                lq[b].delete();
            end
            m_state = 0;
            m_run   = 0;
            m_tick  = 0;
            m_clrn  = 0;
            return;
        end
        smp[0] = s;
        smp[1] = p;
        smp[2] = c;
        for (int b = 0; b < 3; b++) begin
            bit lvl;
            hq[b].push_back(smp[b]);
            n = hq[b].size() - 1;
            ev[b] = lget(b, n - 1) & ~lget(b, n - 2);
`ifdef BTN_DEBOUNCE_EN
            begin
                bit prev;
                bit flip;
                prev = lget(b, n - 1);
                flip = 1'b1;
                for (int k = n - 1 - DB; k <= n - 2; k++)
                    if (hget(b, k) == prev) flip = 1'b0;
                lvl = flip ? ~prev : prev;
            end
`else
            lvl = hget(b, n - 1);
`endif
            lq[b].push_back(lvl);
        end
        m_tick = 0;
        m_clrn = 1;
        if (m_state == 1) begin
            m_run++;
            if (m_run % TD == 0) m_tick = 1;
        end
        if (ev[2]) begin
            m_state = 0;
            m_run   = 0;
            m_tick  = 0;
            m_clrn  = 0;
        end else if (ev[1]) begin
            if (m_state == 1) m_state = 2;
        end else if (ev[0]) begin
            if (m_state != 1) m_state = 1;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input bit c);
        rst       = r;
        start_btn = s;
        stop_btn  = p;
        clear_btn = c;
        @(posedge clk);
        model_edge(r, s, p, c);
        #1;
        chk("state", int'(state), m_state);
        chk("tick", int'(tick), int'(m_tick));
        chk("clr_n", int'(counter_clr_n), int'(m_clrn));
        chk("running", int'(running), int'(m_state == 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(state) != st && n < budget) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk(tag, int'(state), st);
    endtask

    initial begin
        int cnt;
        int trans;
        logic [1:0] last_st;
        bit r, s, p, c;

        rst = 1'b1;
        start_btn = 1'b0;
        stop_btn = 1'b0;
        clear_btn = 1'b0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_clr_n", int'(counter_clr_n), 0);
        cyc(0, 0, 0, 0);
        chk("rel_clr_n", int'(counter_clr_n), 1);

        // start pulse, state changes two edges after the sampling edge
        for (int i = 0; i < PRESS; i++) cyc(0, 1, 0, 0);
`ifndef BTN_DEBOUNCE_EN
        cyc(0, 0, 0, 0);
        chk("start_k1", int'(state), 0);
        cyc(0, 0, 0, 0);
        chk("start_k2", int'(state), 1);
`endif
        wait_state(1, 12, "start_run");

        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0);
            if (tick === 1'b1) cnt++;
        end
        chk("ticks_12", cnt, 3);

        // stop two cycles past a tick, sit paused, resume
        cnt = 0;
        while (tick !== 1'b1 && cnt < 8) begin
            cyc(0, 0, 0, 0);
            cnt++;
        end
        chk("tick_seen", int'(tick), 1);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < PRESS; i++) cyc(0, 0, 1, 0);
        wait_state(2, 12, "stop_pause");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            if (tick === 1'b1) cnt++;
        end
        chk("pause_no_tick", cnt, 0);
        for (int i = 0; i < PRESS; i++) cyc(0, 1, 0, 0);
        wait_state(1, 12, "resume_run");
        idle(6);

        // simultaneous start+stop+clear while running
        for (int i = 0; i < PRESS; i++) cyc(0, 1, 1, 1);
        cnt = 0;
        for (int i = 0; i < 8 + DB; i++) begin
            cyc(0, 0, 0, 0);
            if (counter_clr_n === 1'b0) cnt++;
        end
        chk("clr_pulses", cnt, 1);
        chk("clr_idle", int'(state), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            if (tick === 1'b1) cnt++;
        end
        chk("clr_no_tick", cnt, 0);

        // start held 20 cycles: a single transition
        trans = 0;
        last_st = state;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 0);
            if (state != last_st) trans++;
            last_st = state;
        end
        chk("held_trans", trans, 1);
        chk("held_state", int'(state), 1);
        idle(4);

`ifdef BTN_DEBOUNCE_EN
        for (int i = 0; i < PRESS; i++) cyc(0, 0, 0, 1);
        idle(10);
        chk("db_idle", int'(state), 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        idle(12);
        chk("db_glitch", int'(state), 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        wait_state(1, 12, "db_held");
`endif

        // random phase, including occasional mid-run reset
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 99) < 12);
            p = ($urandom_range(0, 99) < 8);
            c = ($urandom_range(0, 99) < 3);
            cyc(r, s, p, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
